// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the mips_cpu_bus memory responder.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } resp_state_t;

  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  // Replace only the byte lanes selected by be.
  function automatic logic [BUS_DW-1:0] be_merge(
    input logic [BUS_DW-1:0]  old_word,
    input logic [BUS_DW-1:0]  new_word,
    input logic [BUS_BEW-1:0] be
  );
    logic [BUS_DW-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BUS_BEW; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mips_bus_ram_responder_if.sv
// Avalon-style bus between the mips_cpu_bus initiator (master) and a memory responder (slave).
interface mips_bus_ram_responder_if;
  import mips_bus_pkg::*;

  logic               read;
  logic               write;
  logic [31:0]        address;
  logic [BUS_BEW-1:0] byteenable;
  logic [BUS_DW-1:0]  writedata;
  logic               waitrequest;
  logic [BUS_DW-1:0]  readdata;

  modport master (
    output read, write, address, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  read, write, address, byteenable, writedata,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_bus_stall_lfsr.sv
// Random stall-length source: 16-bit Galois LFSR, stall = lfsr[3:0] % (max_stall+1).
// Only present when BUS_RESP_RANDOM_STALL_EN is defined.
`ifdef BUS_RESP_RANDOM_STALL_EN
module mips_bus_stall_lfsr #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic [3:0] max_stall,
  output logic [3:0] stall
);

  logic [15:0] lfsr_reg;
  logic [4:0]  stall_wide;

  // Taps 16,14,13,11 in right-shifting Galois form.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_reg <= LFSR_SEED;
    end else if (advance) begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Five-bit arithmetic so max_stall=15 does not wrap the divisor to zero.
  assign stall_wide = {1'b0, lfsr_reg[3:0]} % ({1'b0, max_stall} + 5'd1);
  assign stall      = stall_wide[3:0];

endmodule
`endif

// File: rtl/mips_bus_ram_responder.sv
// Word-organised RAM responder for mips_cpu_bus with byteenable writes, programmable waitrequest
// stalls and sticky protocol-violation detection. Optional: BUS_RESP_RANDOM_STALL_EN (LFSR stalls).
module mips_bus_ram_responder
  import mips_bus_pkg::*;
#(
  parameter string       RAM_INIT_FILE = "",
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter int          DEPTH_WORDS   = 1024,
  parameter int          STALL_CYCLES  = 1,
  parameter int          MAX_STALL     = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  mips_bus_ram_responder_if.slave  bus,
  output logic                     proto_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  resp_state_t        state_reg;
  logic [3:0]         cnt_reg;
  logic [31:0]        addr_reg;
  logic [BUS_DW-1:0]  wdata_reg;
  logic [BUS_BEW-1:0] be_reg;
  logic               wr_reg;
  logic               proto_err_reg;

  logic [3:0]         stall_s;
  logic               req;
  logic               in_idle;
  logic               zero_wait;
  logic               complete;
  logic               mismatch;
  logic               in_window;
  logic [31:0]        eff_addr;
  logic [31:0]        offset;
  logic [BUS_DW-1:0]  eff_wdata;
  logic [BUS_BEW-1:0] eff_be;
  logic               eff_write;
  logic [AW-1:0]      idx;

  logic [BUS_DW-1:0]  ram [DEPTH_WORDS];

`ifdef BUS_RESP_RANDOM_STALL_EN
  // The LFSR steps once per accepted transaction, i.e. whenever a request is seen in IDLE.
  mips_bus_stall_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_stall_lfsr (
    .clk       (clk),
    .reset     (reset),
    .advance   (in_idle && req),
    .max_stall (4'(MAX_STALL)),
    .stall     (stall_s)
  );
`else
  logic unused_random_cfg;
  assign unused_random_cfg = ^{32'(MAX_STALL), LFSR_SEED};
  assign stall_s           = 4'(STALL_CYCLES);
`endif

  assign req       = bus.read | bus.write;
  assign in_idle   = (state_reg == IDLE);
  assign zero_wait = (stall_s == 4'd0);

  // Held in reset, the responder neither stalls nor completes anything.
  assign complete        = reset & req & ((in_idle & zero_wait) | (state_reg == ACK));
  assign bus.waitrequest = reset & req & (state_reg != ACK) & ~(in_idle & zero_wait);

  // Zero-wait transactions use the live bus; stalled ones use what was latched at accept.
  assign eff_addr  = in_idle ? bus.address    : addr_reg;
  assign eff_wdata = in_idle ? bus.writedata  : wdata_reg;
  assign eff_be    = in_idle ? bus.byteenable : be_reg;
  assign eff_write = in_idle ? bus.write      : wr_reg;

  assign offset    = eff_addr - BASE_ADDR;
  assign in_window = ({1'b0, offset} < WIN_BYTES);
  assign idx       = offset[AW+1:2];

  assign mismatch = (bus.address    != addr_reg)
                  | (bus.writedata  != wdata_reg)
                  | (bus.byteenable != be_reg)
                  | (bus.write      != wr_reg);

  assign bus.readdata = (complete && !eff_write && in_window) ? ram[idx] : '0;
  assign proto_err    = proto_err_reg;

  always_ff @(posedge clk) begin
    if (complete && eff_write && in_window) begin
      ram[idx] <= be_merge(ram[idx], eff_wdata, eff_be);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      wr_reg        <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      if (bus.read && bus.write) proto_err_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (req && !zero_wait) begin
            addr_reg  <= bus.address;
            wdata_reg <= bus.writedata;
            be_reg    <= bus.byteenable;
            wr_reg    <= bus.write;
            if (stall_s == 4'd1) begin
              state_reg <= ACK;
            end else begin
              state_reg <= STALL;
              cnt_reg   <= stall_s - 4'd2;
            end
          end
        end

        STALL: begin
          if (!req) begin
            // Initiator abandoned the transaction: nothing commits.
            proto_err_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            if (mismatch) proto_err_reg <= 1'b1;
            if (cnt_reg == 4'd0) begin
              state_reg <= ACK;
            end else begin
              cnt_reg <= cnt_reg - 4'd1;
            end
          end
        end

        ACK: begin
          if (!req || mismatch) proto_err_reg <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_ram_responder.sv
// Bench for mips_bus_ram_responder: zero-wait and 3-stall instances, vector table, corner sequences, random traffic.
module tb_mips_bus_ram_responder;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 64;
  localparam int          NV    = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic proto_err0, proto_err3;

  logic        rd_in   [2];
  logic        wr_in   [2];
  logic [31:0] addr_in [2];
  logic [3:0]  be_in   [2];
  logic [31:0] wd_in   [2];

  mips_bus_ram_responder_if bus0 ();
  mips_bus_ram_responder_if bus3 ();

  assign bus0.read       = rd_in[0];
  assign bus0.write      = wr_in[0];
  assign bus0.address    = addr_in[0];
  assign bus0.byteenable = be_in[0];
  assign bus0.writedata  = wd_in[0];
  assign bus3.read       = rd_in[1];
  assign bus3.write      = wr_in[1];
  assign bus3.address    = addr_in[1];
  assign bus3.byteenable = be_in[1];
  assign bus3.writedata  = wd_in[1];

  mips_bus_ram_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .STALL_CYCLES(0)
  ) u0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .proto_err(proto_err0)
  );

  mips_bus_ram_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .STALL_CYCLES(3)
  ) u3 (
    .clk(clk), .reset(reset), .bus(bus3.slave), .proto_err(proto_err3)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference memory: one image per instance, plus which words hold a known value.
  logic [31:0] mem_m [2][DEPTH];
  bit          vld_m [2][DEPTH];

  typedef struct {
    int          sel;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_waits;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic wreq(input int sel);
    return (sel == 0) ? bus0.waitrequest : bus3.waitrequest;
  endfunction

  function automatic logic [31:0] rdat(input int sel);
    return (sel == 0) ? bus0.readdata : bus3.readdata;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  task automatic model_write(input int sel, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    int w;
    if (in_win(a)) begin
      w = widx(a);
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_m[sel][w][8*l +: 8] = wd[8*l +: 8];
      end
      if (be == 4'hF) vld_m[sel][w] = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge.
  task automatic txn(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd, input bit hold,
                     output logic [31:0] rdata, output int waits);
    bit done;
    rd_in[sel] = rd; wr_in[sel] = wr; addr_in[sel] = addr; be_in[sel] = be; wd_in[sel] = wd;
    waits = 0;
    rdata = '0;
    done  = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!wreq(sel)) begin
        rdata = rdat(sel);
        done  = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL txn_timeout: sel=%0d addr=%h still stalled after %0d cycles, expected completion", sel, addr, waits);
    end
    @(posedge clk); #1;
    if (!hold) begin
      rd_in[sel] = 1'b0;
      wr_in[sel] = 1'b0;
    end
    $display("txn sel=%0d rd=%0b wr=%0b addr=%h be=%h wd=%h -> rdata=%h waits=%0d",
             sel, rd, wr, addr, be, wd, rdata, waits);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [31:0] rdata, addr, wd;
  logic [3:0]  be;
  logic        wr;
  int          waits, sel, next_sel, w;
  bit          hold;

  initial begin
    vecs[0]  = '{0, 1'b0, 1'b1, 32'hBFC00000, 4'hF, 32'h24020005, 32'h00000000, 0};
    vecs[1]  = '{0, 1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h00000000, 32'h24020005, 0};
    vecs[2]  = '{1, 1'b0, 1'b1, 32'hBFC00000, 4'hF, 32'h0BADF00D, 32'h00000000, 3};
    vecs[3]  = '{1, 1'b0, 1'b1, 32'hBFC00004, 4'hF, 32'hAABBCCDD, 32'h00000000, 3};
    vecs[4]  = '{1, 1'b0, 1'b1, 32'hBFC00004, 4'h5, 32'h11223344, 32'h00000000, 3};
    vecs[5]  = '{1, 1'b1, 1'b0, 32'hBFC00004, 4'hF, 32'h00000000, 32'hAA22CC44, 3};
    vecs[6]  = '{1, 1'b0, 1'b1, 32'h00000000, 4'hF, 32'hDEADBEEF, 32'h00000000, 3};
    vecs[7]  = '{1, 1'b1, 1'b0, 32'h00000000, 4'hF, 32'h00000000, 32'h00000000, 3};
    vecs[8]  = '{1, 1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h00000000, 32'h0BADF00D, 3};
    vecs[9]  = '{1, 1'b1, 1'b0, 32'hBFC00100, 4'hF, 32'h00000000, 32'h00000000, 3};
    vecs[10] = '{1, 1'b1, 1'b0, 32'hBFC00007, 4'hF, 32'h00000000, 32'hAA22CC44, 3};
    vecs[11] = '{0, 1'b0, 1'b1, 32'hBFC000FC, 4'hF, 32'h12345678, 32'h00000000, 0};
    vecs[12] = '{0, 1'b1, 1'b0, 32'hBFC000FC, 4'hF, 32'h00000000, 32'h12345678, 0};
    vecs[13] = '{0, 1'b1, 1'b0, 32'hBFC00100, 4'hF, 32'h00000000, 32'h00000000, 0};
    vecs[14] = '{0, 1'b1, 1'b0, 32'hBFBFFFFC, 4'hF, 32'h00000000, 32'h00000000, 0};
    vecs[15] = '{0, 1'b0, 1'b1, 32'hBFC000FC, 4'h8, 32'h99000000, 32'h00000000, 0};
    vecs[16] = '{0, 1'b1, 1'b0, 32'hBFC000FC, 4'hF, 32'h00000000, 32'h99345678, 0};

    for (int s = 0; s < 2; s++) begin
      rd_in[s] = 1'b0; wr_in[s] = 1'b0; addr_in[s] = '0; be_in[s] = '0; wd_in[s] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[s][i] = '0;
        vld_m[s][i] = 1'b0;
      end
    end

    // Reset state
    reset = 1'b0;
    #12;
    check("rst_wait0",  32'(bus0.waitrequest), 32'd0);
    check("rst_wait3",  32'(bus3.waitrequest), 32'd0);
    check("rst_rdata0", bus0.readdata, 32'd0);
    check("rst_rdata3", bus3.readdata, 32'd0);
    check("rst_perr0",  32'(proto_err0), 32'd0);
    check("rst_perr3",  32'(proto_err3), 32'd0);
    #10;
    reset = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      txn(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, 1'b0, rdata, waits);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
      if (vecs[i].wr) model_write(vecs[i].sel, vecs[i].addr, vecs[i].be, vecs[i].wd);
    end
    check("table_perr0", 32'(proto_err0), 32'd0);
    check("table_perr3", 32'(proto_err3), 32'd0);

    // Reset in the middle of a stalled write: stall drops at once, nothing commits
    rd_in[1] = 1'b0; wr_in[1] = 1'b1; addr_in[1] = 32'hBFC00004; be_in[1] = 4'hF; wd_in[1] = 32'h55555555;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_wait_before", 32'(bus3.waitrequest), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_wait_now", 32'(bus3.waitrequest), 32'd0);
    @(negedge clk);
    wr_in[1] = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_perr3", 32'(proto_err3), 32'd0);
    txn(1, 1'b1, 1'b0, 32'hBFC00004, 4'hF, 32'h0, 1'b0, rdata, waits);
    check("midrst_ram", rdata, 32'hAA22CC44);

    // Write dropped mid-stall: flagged, no commit, FSM back in IDLE next cycle
    txn(1, 1'b0, 1'b1, 32'hBFC00008, 4'hF, 32'h13579BDF, 1'b0, rdata, waits);
    model_write(1, 32'hBFC00008, 4'hF, 32'h13579BDF);
    wr_in[1] = 1'b1; addr_in[1] = 32'hBFC00008; wd_in[1] = 32'h2468ACE0;
    @(posedge clk); #1;
    wr_in[1] = 1'b0;
    @(posedge clk); #1;
    check("drop_perr3", 32'(proto_err3), 32'd1);
    txn(1, 1'b1, 1'b0, 32'hBFC00008, 4'hF, 32'h0, 1'b0, rdata, waits);
    check("drop_ram", rdata, 32'h13579BDF);
    check("drop_idle_waits", 32'(waits), 32'd3);
    check("drop_sticky", 32'(proto_err3), 32'd1);

    // read && write together: flagged and performed as a write
    txn(0, 1'b1, 1'b1, 32'hBFC00010, 4'hF, 32'h0F0F0F0F, 1'b0, rdata, waits);
    model_write(0, 32'hBFC00010, 4'hF, 32'h0F0F0F0F);
    check("rw_perr0", 32'(proto_err0), 32'd1);
    txn(0, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 1'b0, rdata, waits);
    check("rw_as_write", rdata, 32'h0F0F0F0F);

    // Address changed during stall: flagged, latched address still used
    pulse_reset();
    check("chg_perr3_cleared", 32'(proto_err3), 32'd0);
    rd_in[1] = 1'b1; wr_in[1] = 1'b0; addr_in[1] = 32'hBFC00004; be_in[1] = 4'hF; wd_in[1] = 32'h0;
    @(posedge clk); #1;
    addr_in[1] = 32'hBFC00008;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("chg_ack_wait", 32'(bus3.waitrequest), 32'd0);
    check("chg_latched_rdata", bus3.readdata, 32'hAA22CC44);
    @(posedge clk); #1;
    rd_in[1] = 1'b0;
    check("chg_perr3", 32'(proto_err3), 32'd1);

    // Random traffic against the reference model, with back-to-back holds
    pulse_reset();
    next_sel = int'($urandom_range(1, 0));
    for (int t = 0; t < 60; t++) begin
      sel      = next_sel;
      next_sel = int'($urandom_range(1, 0));
      wr       = 1'($urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0) addr = $urandom;
      else addr = BASE + 32'($urandom_range(7, 0)) * 32'd4 + 32'($urandom_range(3, 0));
      be   = 4'($urandom);
      wd   = $urandom;
      hold = (next_sel == sel) && ($urandom_range(1, 0) == 1) && (t != 59);
      txn(sel, !wr, wr, addr, be, wd, hold, rdata, waits);
      check($sformatf("rnd%0d_waits", t), 32'(waits), (sel == 0) ? 32'd0 : 32'd3);
      if (wr) begin
        check($sformatf("rnd%0d_wr_rdata", t), rdata, 32'd0);
        model_write(sel, addr, be, wd);
      end else if (!in_win(addr)) begin
        check($sformatf("rnd%0d_oow_rdata", t), rdata, 32'd0);
      end else begin
        w = widx(addr);
        if (vld_m[sel][w]) check($sformatf("rnd%0d_rdata", t), rdata, mem_m[sel][w]);
      end
      if (!hold && $urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end
    check("rnd_perr0", 32'(proto_err0), 32'd0);
    check("rnd_perr3", 32'(proto_err3), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
